fifo_rr_read_sched: RTL and testbench

Round-robin read scheduler that shares one downstream readout link between NSRC circular-buffer FIFOs, each run by a write/read address controller. The block watches each source's empty flag and word count. It grants one non-empty source at a time and drives that source's rden to drain a burst of up to MAXBURST words. Each word is registered into a valid/ready output stage tagged with its source index and an end-of-burst flag. It sits between the per-column hit buffers and the frame builder.

---
 rtl/fifo_rr_read_sched_pkg.sv | 10 +
 rtl/fifo_rr_read_sched_rr_pick.sv | 21 ++
 rtl/fifo_rr_read_sched.sv | 103 ++++++++++
 tb/tb_fifo_rr_read_sched.sv | 213 +++++++++++++++++++++
 4 files changed

// File: rtl/fifo_rr_read_sched_pkg.sv
// fifo_rr_read_sched_pkg: shared state encoding, default burst length and last-word compare
package fifo_rr_read_sched_pkg;
  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_BURST = 1'b1;
  localparam int DEF_MAXBURST = 8;
  // a count of 0 on a non-empty source means a wrapped full FIFO, so only 1 ends a burst by count
  function automatic logic last_word(input logic [31:0] cnt, input logic [31:0] burst_cnt, input int maxburst);
    return (burst_cnt == 32'(maxburst - 1)) || (cnt == 32'd1);
  endfunction
endpackage

// File: rtl/fifo_rr_read_sched_rr_pick.sv
// fifo_rr_read_sched_rr_pick: combinational round-robin picker searching upward from last grant + 1
module fifo_rr_read_sched_rr_pick #(
  parameter int NSRC = 4,
  parameter int SW = 2
) (
  input  logic [NSRC-1:0] i_req,
  input  logic [SW-1:0]   i_last,
  output logic [SW-1:0]   o_grant,
  output logic            o_any
);
  logic [SW-1:0] w_idx;
  always_comb begin
    o_grant = '0;
    w_idx = '0;
    for (int k = NSRC; k >= 1; k--) begin
      w_idx = SW'((32'(i_last) + 32'(k)) % 32'(NSRC));
      o_grant = i_req[w_idx] ? w_idx : o_grant;
    end
  end
  assign o_any = |i_req;
endmodule

// File: rtl/fifo_rr_read_sched.sv
// fifo_rr_read_sched: round-robin burst reader sharing one valid/ready link between NSRC FIFOs
module fifo_rr_read_sched
  import fifo_rr_read_sched_pkg::*;
#(
  parameter int NSRC = 4,
  parameter int DW = 16,
  parameter int CW = 4,
  parameter int MAXBURST = DEF_MAXBURST,
  parameter int SW = $clog2(NSRC)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_enable,
  input  logic [NSRC-1:0]    i_src_empty,
  input  logic [NSRC*CW-1:0] i_src_word_count,
  input  logic [NSRC*DW-1:0] i_src_data,
  output logic [NSRC-1:0]    o_rden,
  output logic               o_out_valid,
  input  logic               i_out_ready,
  output logic [DW-1:0]      o_out_data,
  output logic [SW-1:0]      o_out_src,
  output logic               o_out_last,
  output logic               o_busy,
  output logic               o_err_underrun
);
  logic [0:0]    r_state;
  logic [SW-1:0] r_grant;
  logic [SW-1:0] r_last_grant;
  logic [CW-1:0] r_burst_cnt;
  logic          r_err;
  logic          r_out_valid;
  logic [DW-1:0] r_out_data;
  logic [SW-1:0] r_out_src;
  logic          r_out_last;
  logic [SW-1:0] w_pick;
  logic          w_any;
  logic          w_empty_g;
  logic [CW-1:0] w_cnt_g;
  logic [DW-1:0] w_data_g;
  logic          w_load;
  logic          w_last;

  fifo_rr_read_sched_rr_pick #(.NSRC(NSRC), .SW(SW)) u_rr_pick (
    .i_req  (~i_src_empty),
    .i_last (r_last_grant),
    .o_grant(w_pick),
    .o_any  (w_any)
  );

  assign w_empty_g = i_src_empty[r_grant];
  assign w_cnt_g = i_src_word_count[r_grant*CW +: CW];
  assign w_data_g = i_src_data[r_grant*DW +: DW];
  assign w_load = (r_state == ST_BURST) && !w_empty_g && (!r_out_valid || i_out_ready);
  assign w_last = last_word(32'(w_cnt_g), 32'(r_burst_cnt), MAXBURST);
  // rden is the FIFO's read-advance strobe for the head word sampled on this edge
  assign o_rden = w_load ? NSRC'(1'b1) << r_grant : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_IDLE;
      r_grant <= '0;
      r_last_grant <= SW'(NSRC - 1);
      r_burst_cnt <= '0;
      r_err <= 1'b0;
    end else if (r_state == ST_IDLE) begin
      if (i_enable && w_any) begin
        r_state <= ST_BURST;
        r_grant <= w_pick;
        r_last_grant <= w_pick;
        r_burst_cnt <= '0;
      end
    end else if (w_empty_g) begin
      r_err <= 1'b1;
      r_state <= ST_IDLE;
    end else if (w_load) begin
      r_burst_cnt <= r_burst_cnt + CW'(1);
      if (w_last) r_state <= ST_IDLE;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data <= '0;
      r_out_src <= '0;
      r_out_last <= 1'b0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data <= w_data_g;
      r_out_src <= r_grant;
      r_out_last <= w_last;
    end else if (r_out_valid && i_out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign o_out_valid = r_out_valid;
  assign o_out_data = r_out_data;
  assign o_out_src = r_out_src;
  assign o_out_last = r_out_last;
  assign o_busy = (r_state != ST_IDLE);
  assign o_err_underrun = r_err;
endmodule

// File: tb/tb_fifo_rr_read_sched.sv
// tb_fifo_rr_read_sched: directed phases plus random traffic against a queue-based reference model
module tb_fifo_rr_read_sched;
  localparam int NSRC = 4;
  localparam int MAXB = 8;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic rdy = 1'b0;
  logic [3:0] empty;
  logic [15:0] cnts;
  logic [63:0] data;
  logic [3:0] fmask = 4'b0;
  logic [3:0] o_rden;
  logic o_out_valid, o_out_last, o_busy, o_err_underrun;
  logic [15:0] o_out_data;
  logic [1:0] o_out_src;

  fifo_rr_read_sched dut (
    .clk(clk), .rst_n(rst_n), .i_enable(en), .i_src_empty(empty),
    .i_src_word_count(cnts), .i_src_data(data), .o_rden(o_rden),
    .o_out_valid(o_out_valid), .i_out_ready(rdy), .o_out_data(o_out_data),
    .o_out_src(o_out_src), .o_out_last(o_out_last), .o_busy(o_busy),
    .o_err_underrun(o_err_underrun)
  );

  always #5 clk = ~clk;

  int mem[4][16];
  int rp[4];
  int sz[4];
  int nrden[4];
  int ends[$];
  int errors = 0;
  int checks = 0;
  bit mb, mv, ml, merr;
  int mg, mlg, mn, md, ms;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push(input int s, input int v);
    if (sz[s] < 16) begin
      mem[s][(rp[s] + sz[s]) % 16] = v;
      sz[s]++;
    end
  endtask

  task automatic push_n(input int s, input int n);
    for (int i = 0; i < n; i++) push(s, int'($urandom_range(0, 65535)));
  endtask

  task automatic drive();
    for (int s = 0; s < NSRC; s++) begin
      empty[s] = (sz[s] == 0) || fmask[s];
      cnts[s*4 +: 4] = 4'(sz[s]);
      data[s*16 +: 16] = 16'(mem[s][rp[s]]);
    end
  endtask

  task automatic model_reset();
    mb = 0; mv = 0; ml = 0; merr = 0;
    mg = 0; mlg = NSRC - 1; mn = 0; md = 0; ms = 0;
  endtask

  // called at a falling edge; models the transition on the next rising edge and returns at the following falling edge
  task automatic step(input bit e, input bit r, input logic [3:0] f);
    bit load, was_b, found;
    int c, idx;
    logic [3:0] er;
    en = e; rdy = r; fmask = f;
    drive();
    #1;
    was_b = mb;
    load = mb && !empty[mg] && (!mv || rdy);
    er = load ? 4'(1 << mg) : 4'b0;
    chk("rden", 64'(o_rden), 64'(er));
    chk("busy", 64'(o_busy), 64'(mb));
    chk("valid", 64'(o_out_valid), 64'(mv));
    chk("err", 64'(o_err_underrun), 64'(merr));
    if (mv) begin
      chk("data", 64'(o_out_data), 64'(md));
      chk("src", 64'(o_out_src), 64'(ms));
      chk("last", 64'(o_out_last), 64'(ml));
    end
    if (o_out_valid && rdy && o_out_last) ends.push_back(int'(o_out_src));
    if (load) begin
      c = int'(cnts[mg*4 +: 4]);
      md = mem[mg][rp[mg]];
      ms = mg;
      ml = (mn + 1 == MAXB) || (c == 1);
      mv = 1;
      mn++;
      nrden[mg]++;
      rp[mg] = (rp[mg] + 1) % 16;
      sz[mg]--;
      if (ml) mb = 0;
    end else if (mv && rdy) begin
      mv = 0;
    end
    if (was_b && empty[mg]) begin
      merr = 1;
      mb = 0;
    end
    if (!was_b && e) begin
      found = 0;
      for (int k = 1; k <= NSRC; k++) begin
        idx = (mlg + k) % NSRC;
        if (!found && !empty[idx]) begin
          found = 1;
          mg = idx;
        end
      end
      if (found) begin
        mlg = mg; mn = 0; mb = 1;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n, input bit e, input bit r);
    for (int i = 0; i < n; i++) step(e, r, 4'b0);
  endtask

  // asserted at a falling edge so the checks see the asynchronous clear before any rising edge
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    chk("rst_valid", 64'(o_out_valid), 64'd0);
    chk("rst_rden", 64'(o_rden), 64'd0);
    chk("rst_busy", 64'(o_busy), 64'd0);
    chk("rst_err", 64'(o_err_underrun), 64'd0);
    chk("rst_last", 64'(o_out_last), 64'd0);
    chk("rst_data", 64'(o_out_data), 64'd0);
    chk("rst_src", 64'(o_out_src), 64'd0);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    int exp_seq[5];
    int base;
    exp_seq = '{0, 1, 2, 3, 0};
    for (int s = 0; s < NSRC; s++) begin
      rp[s] = 0; sz[s] = 0; nrden[s] = 0;
    end
    model_reset();
    drive();
    @(negedge clk);
    do_reset();

    push_n(2, 3);
    ends.delete();
    run(8, 1, 1);
    chk("ph1_rden2", 64'(nrden[2]), 64'd3);
    chk("ph1_nends", 64'(ends.size()), 64'd1);
    if (ends.size() > 0) chk("ph1_src", 64'(ends[0]), 64'd2);
    chk("ph1_idle", 64'(o_busy), 64'd0);

    for (int s = 0; s < NSRC; s++) push_n(s, 15);
    do_reset();
    ends.delete();
    run(50, 1, 1);
    chk("ph2_nbursts", 64'(ends.size() >= 5), 64'd1);
    for (int i = 0; i < 5; i++) if (i < ends.size()) chk("ph2_order", 64'(ends[i]), 64'(exp_seq[i]));
    run(120, 1, 1);
    chk("ph2_drained", 64'(sz[0] + sz[1] + sz[2] + sz[3]), 64'd0);

    push_n(0, 6);
    base = nrden[0];
    for (int i = 0; i < 32; i++) step(1, (i % 4 == 0) || (i % 4 == 3), 4'b0);
    chk("ph3_words", 64'(nrden[0] - base), 64'd6);

    push_n(1, 5);
    base = nrden[1];
    run(3, 1, 1);
    push_n(0, 3); push_n(2, 3); push_n(3, 3);
    run(12, 0, 1);
    chk("ph4_words", 64'(nrden[1] - base), 64'd5);
    chk("ph4_nogrant", 64'(o_busy), 64'd0);
    chk("ph4_src0_idle", 64'(sz[0]), 64'd3);

    run(2, 1, 1);
    step(1, 1, 4'(1 << mg));
    run(3, 1, 1);
    chk("ph5_err", 64'(o_err_underrun), 64'd1);
    run(30, 1, 1);
    chk("ph5_sticky", 64'(o_err_underrun), 64'd1);

    push_n(2, 10); push_n(0, 10);
    run(5, 1, 1);
    do_reset();
    base = nrden[0];
    run(2, 1, 1);
    chk("ph6_first", 64'(nrden[0] - base), 64'd1);
    run(40, 1, 1);

    for (int i = 0; i < 800; i++) begin
      if ($urandom_range(0, 9) < 3) push(int'($urandom_range(0, 3)), int'($urandom_range(0, 65535)));
      if ($urandom_range(0, 199) == 0) do_reset();
      else step($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0,
                ($urandom_range(0, 49) == 0) ? 4'(1 << $urandom_range(0, 3)) : 4'b0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
